// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB-first, WIDTH+1 cycles per result.
// Optional signed-overflow output enabled by defining BIT_SERIAL_ADDER_OVF_EN.
module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef BIT_SERIAL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             c_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-2:0] sum_sh_r;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] sum_r;
   logic             c_out_r;
   logic             load_s;
   logic             last_s;
   logic [1:0]       fa_s;
   logic [WIDTH-1:0] sum_nxt_s;
`ifdef BIT_SERIAL_ADDER_OVF_EN
   logic             ovf_r;
`endif

   // Single full-adder cell: returns {carry_out, sum_bit}.
   function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
      full_adder = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
   endfunction

   assign load_s    = start && (state_r != S_RUN);
   assign last_s    = (state_r == S_RUN) && (cnt_r == LAST_BIT);
   assign fa_s      = full_adder(a_sh_r[0], b_sh_r[0], carry_r);
   // New sum bit enters at the MSB; bit 0 is only ever consumed by the final copy into sum.
   assign sum_nxt_s = {fa_s[0], sum_sh_r};

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (load_s) state_nxt_s = S_RUN;
            else        state_nxt_s = S_IDLE;
         end
         S_RUN: begin
            if (last_s) state_nxt_s = S_DONE;
            else        state_nxt_s = S_RUN;
         end
         S_DONE: begin
            if (load_s) state_nxt_s = S_RUN;
            else        state_nxt_s = S_IDLE;
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Status outputs decoded from the state flop.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_r)
         S_IDLE:  begin busy = 1'b0; done = 1'b0; end
         S_RUN:   begin busy = 1'b1; done = 1'b0; end
         S_DONE:  begin busy = 1'b0; done = 1'b1; end
         default: begin busy = 1'b0; done = 1'b0; end
      endcase
   end

   // Operand shifters, carry, bit counter and result capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh_r   <= {WIDTH{1'b0}};
         b_sh_r   <= {WIDTH{1'b0}};
         sum_sh_r <= {(WIDTH-1){1'b0}};
         carry_r  <= 1'b0;
         cnt_r    <= {CW{1'b0}};
         sum_r    <= {WIDTH{1'b0}};
         c_out_r  <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
         ovf_r    <= 1'b0;
`endif
      end else if (load_s) begin
         a_sh_r  <= a;
         b_sh_r  <= b;
         carry_r <= c_in;
         cnt_r   <= {CW{1'b0}};
      end else if (state_r == S_RUN) begin
         a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
         b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
         sum_sh_r <= sum_nxt_s[WIDTH-1:1];
         carry_r  <= fa_s[1];
         cnt_r    <= cnt_r + CW'(1);
         if (last_s) begin
            sum_r   <= sum_nxt_s;
            c_out_r <= fa_s[1];
`ifdef BIT_SERIAL_ADDER_OVF_EN
            // carry_r here is the carry into the MSB.
            ovf_r   <= carry_r ^ fa_s[1];
`endif
         end
      end
   end

   assign sum   = sum_r;
   assign c_out = c_out_r;
`ifdef BIT_SERIAL_ADDER_OVF_EN
   assign ovf   = ovf_r;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder (WIDTH=8).
module tb_bit_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       c_in;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       c_out;
`ifdef BIT_SERIAL_ADDER_OVF_EN
   logic       ovf;
`endif

   int total = 0;
   int bad   = 0;

   bit_serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef BIT_SERIAL_ADDER_OVF_EN
      .ovf   (ovf),
`endif
      .c_out (c_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for done; returns edges waited and busy cycles seen.
   task automatic wait_done(output int cyc, output int busy_cyc);
      cyc = 0;
      busy_cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy === 1'b1) busy_cyc++;
         tick();
         cyc++;
      end
   endtask

   task automatic go(input logic [7:0] av, input logic [7:0] bv, input logic ci);
      a = av; b = bv; c_in = ci; start = 1'b1;
      tick();
      start = 1'b0; a = 8'h00; b = 8'h00; c_in = 1'b0;
   endtask

   initial begin
      int cyc;
      int bcyc;
      int seen;

      rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; c_in = 1'b0;
      tick(); tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sum", {24'd0, sum}, 32'h00);
      chk("rst_cout", {31'd0, c_out}, 32'd0);
      rst_n = 1'b1;
      tick();

      // 0x3C + 0x42
      go(8'h3C, 8'h42, 1'b0);
      wait_done(cyc, bcyc);
      chk("t1_lat", cyc, 32'd8);
      chk("t1_busycyc", bcyc, 32'd8);
      chk("t1_done", {31'd0, done}, 32'd1);
      chk("t1_busy_at_done", {31'd0, busy}, 32'd0);
      chk("t1_sum", {24'd0, sum}, 32'h7E);
      chk("t1_cout", {31'd0, c_out}, 32'd0);
      tick();
      chk("t1_done_pulse", {31'd0, done}, 32'd0);
      chk("t1_sum_hold", {24'd0, sum}, 32'h7E);

      // 0xFF + 0x01, then back-to-back 0x5A + 0xA5 + 1
      go(8'hFF, 8'h01, 1'b0);
      wait_done(cyc, bcyc);
      chk("t2_done", {31'd0, done}, 32'd1);
      chk("t2_sum", {24'd0, sum}, 32'h00);
      chk("t2_cout", {31'd0, c_out}, 32'd1);
`ifdef BIT_SERIAL_ADDER_OVF_EN
      chk("t2_ovf", {31'd0, ovf}, 32'd0);
`endif
      go(8'h5A, 8'hA5, 1'b1);
      chk("t3_busy", {31'd0, busy}, 32'd1);
      wait_done(cyc, bcyc);
      chk("t3_gap", cyc + 1, 32'd9);
      chk("t3_sum", {24'd0, sum}, 32'h00);
      chk("t3_cout", {31'd0, c_out}, 32'd1);
      tick();

      // start during RUN is ignored
      go(8'h10, 8'h20, 1'b0);
      tick(); tick();
      a = 8'hFF; b = 8'hFF; c_in = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; a = 8'h00; b = 8'h00; c_in = 1'b0;
      wait_done(cyc, bcyc);
      chk("t4_lat", cyc + 3, 32'd8);
      chk("t4_sum", {24'd0, sum}, 32'h30);
      chk("t4_cout", {31'd0, c_out}, 32'd0);
      tick();
      chk("t4_idle", {31'd0, busy}, 32'd0);

      // reset mid-RUN aborts
      go(8'hAA, 8'h55, 1'b0);
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_sum", {24'd0, sum}, 32'h00);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) seen++;
         tick();
      end
      chk("t5_no_done", seen, 32'd0);
      go(8'h01, 8'h01, 1'b0);
      wait_done(cyc, bcyc);
      chk("t5_sum2", {24'd0, sum}, 32'h02);
      chk("t5_cout2", {31'd0, c_out}, 32'd0);
      tick();

`ifdef BIT_SERIAL_ADDER_OVF_EN
      go(8'h7F, 8'h01, 1'b0);
      wait_done(cyc, bcyc);
      chk("ovf_sum", {24'd0, sum}, 32'h80);
      chk("ovf_flag", {31'd0, ovf}, 32'd1);
      chk("ovf_cout", {31'd0, c_out}, 32'd0);
      tick();
      go(8'hFF, 8'h01, 1'b0);
      wait_done(cyc, bcyc);
      chk("ovf_clear", {31'd0, ovf}, 32'd0);
      chk("ovf_cout2", {31'd0, c_out}, 32'd1);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
